// File: rtl/dap_cmd_dispatcher.sv
// dap_cmd_dispatcher: peeks the CMSIS-DAP command ID at the head of the host
// request stream, starts exactly one matching handler, routes the stream
// handshake to it, and presents its response length for upload. Unknown IDs
// and handlers that overrun their time budget produce a one-byte 0xFF reply.
module dap_cmd_dispatcher #(
  parameter int                   CMD_NUM        = 4,
  parameter logic [CMD_NUM*8-1:0] CMD_IDS        = 32'h1D12_0605,
  parameter logic [31:0]          TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dap_in_tvalid,
  input  logic [7:0]         dap_in_tdata,
  output logic               dap_in_tready,
  input  logic [CMD_NUM-1:0] cmd_tready,
  output logic [CMD_NUM-1:0] start,
  input  logic [CMD_NUM-1:0] done,
  input  logic [9:0]         packet_len,
  output logic               err_ram_write_en,
  output logic [9:0]         err_ram_write_addr,
  output logic [7:0]         err_ram_write_data,
  output logic               resp_valid,
  output logic [9:0]         resp_len,
  input  logic               resp_ready,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_RUN,
    S_UNKNOWN,
    S_RESP
  } state_e;

  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

  state_e             state_q, state_d;
  logic [7:0]         cmd_id_q, cmd_id_d;
  logic [CMD_NUM-1:0] start_q, start_d;
  logic [9:0]         resp_len_q, resp_len_d;
  logic [31:0]        tmo_cnt_q, tmo_cnt_d;

  logic [CMD_NUM-1:0] match_onehot;
  logic               match_found;
  logic               sel_done;
  logic               tmo_hit;

  // Lowest-index table entry equal to the peeked ID wins; duplicates above it are shadowed.
  always_comb begin
    match_onehot = '0;
    match_found  = 1'b0;
    for (int i = 0; i < CMD_NUM; i++) begin
      if (!match_found && (CMD_IDS[8*i +: 8] == cmd_id_q)) begin
        match_onehot[i] = 1'b1;
        match_found     = 1'b1;
      end
    end
  end

  // Only the running slot's done counts; the counter stops at the last allowed cycle.
  assign sel_done = |(done & start_q);
  assign tmo_hit  = (tmo_cnt_q == TIMEOUT_LAST);

  // State register and datapath flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cmd_id_q   <= '0;
      start_q    <= '0;
      resp_len_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
      state_q    <= state_d;
      cmd_id_q   <= cmd_id_d;
      start_q    <= start_d;
      resp_len_q <= resp_len_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  // Next-state and combinational outputs for the dispatch sequence.
  always_comb begin
    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    state_d          = state_q;
    cmd_id_d         = cmd_id_q;
    start_d          = start_q;
    resp_len_d       = resp_len_q;
    tmo_cnt_d        = tmo_cnt_q;
    dap_in_tready    = 1'b0;
    err_ram_write_en = 1'b0;
    timeout_err      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Peek only: the ID byte stays in the stream for the handler to consume.
        if (dap_in_tvalid) begin
          cmd_id_d = dap_in_tdata;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        tmo_cnt_d = '0;
        if (match_found) begin
          start_d = match_onehot;
          state_d = S_RUN;
        end else begin
          state_d = S_UNKNOWN;
        end
      end
      S_RUN: begin
        dap_in_tready = |(cmd_tready & start_q);
        if (sel_done) begin
          start_d    = '0;
          resp_len_d = packet_len;
          state_d    = S_RESP;
        end else if (tmo_hit) begin
          start_d          = '0;
          timeout_err      = 1'b1;
          err_ram_write_en = 1'b1;
          resp_len_d       = 10'd1;
          state_d          = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      S_UNKNOWN: begin
        // Drop the unrecognised ID byte and answer with a single 0xFF.
        dap_in_tready    = 1'b1;
        err_ram_write_en = 1'b1;
        resp_len_d       = 10'd1;
        state_d          = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err_ram_write_addr = '0;
  assign err_ram_write_data = err_ram_write_en ? 8'hFF : 8'h00;
  assign start              = start_q;
  assign resp_len           = resp_len_q;
  assign resp_valid         = (state_q == S_RESP);
  assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_dap_cmd_dispatcher.sv
// tb_dap_cmd_dispatcher: randomized commands against a table-lookup reference
// model. Expected responses are queued when a command is issued; a monitor pops
// and compares whenever a response is handed to the upload path.
module tb_dap_cmd_dispatcher;

  localparam int          CMD_NUM = 4;
  localparam logic [31:0] IDS     = 32'h0612_0605;  // 0x06 duplicated in slots 1 and 3
  localparam logic [31:0] TMO     = 32'd16;

  logic               clk = 1'b0;
  logic               reset;
  logic               dap_in_tvalid;
  logic [7:0]         dap_in_tdata;
  logic               dap_in_tready;
  logic [CMD_NUM-1:0] cmd_tready;
  logic [CMD_NUM-1:0] start;
  logic [CMD_NUM-1:0] done;
  logic [9:0]         packet_len;
  logic               err_ram_write_en;
  logic [9:0]         err_ram_write_addr;
  logic [7:0]         err_ram_write_data;
  logic               resp_valid;
  logic [9:0]         resp_len;
  logic               resp_ready;
  logic               busy;
  logic               timeout_err;

  dap_cmd_dispatcher #(
    .CMD_NUM(CMD_NUM), .CMD_IDS(IDS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .dap_in_tvalid(dap_in_tvalid), .dap_in_tdata(dap_in_tdata), .dap_in_tready(dap_in_tready),
    .cmd_tready(cmd_tready), .start(start), .done(done), .packet_len(packet_len),
    .err_ram_write_en(err_ram_write_en), .err_ram_write_addr(err_ram_write_addr),
    .err_ram_write_data(err_ram_write_data),
    .resp_valid(resp_valid), .resp_len(resp_len), .resp_ready(resp_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] len;
    logic [3:0] start_oh;
    int         beats;
    int         errw;
    int         tos;
    int         runc;   // -1: run length not predicted
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] ref_ids [4] = '{8'h05, 8'h06, 8'h12, 8'h06};

  // Handler behaviour knobs, set by the stimulus before each command.
  int         hnd_bytes = 1;
  int         hnd_mode  = 0;   // 0 normal, 1 never done, 2 done on the last allowed cycle
  bit         hnd_spur  = 1'b0;
  bit         hnd_en    = 1'b1;
  logic [9:0] hnd_plen  = '0;
  bit         mon_en    = 1'b1;
  int         run_cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_slot(input logic [7:0] id);
    for (int i = 0; i < 4; i++) if (ref_ids[i] == id) return i;
    return -1;
  endfunction

  // Number of consecutive sampled cycles with a start bit high.
  initial begin
    forever begin
      @(negedge clk);
      run_cyc = (start != '0) ? run_cyc + 1 : 0;
    end
  end

  // Monitor: accumulate per-command observations, compare on response handshake.
  initial begin : monitor
    int         m_beats, m_errw, m_tos, m_runc;
    logic [3:0] m_start_or;
    exp_t       e;
    m_beats = 0; m_errw = 0; m_tos = 0; m_runc = 0; m_start_or = '0;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (dap_in_tready) m_beats++;
        if (err_ram_write_en) begin
          m_errw++;
          check("err_addr", err_ram_write_addr, 10'd0);
          check("err_data", err_ram_write_data, 8'hFF);
        end
        if (timeout_err) m_tos++;
        if (start != '0) begin
          m_runc++;
          m_start_or |= start;
        end
        if (resp_valid && resp_ready) begin
          check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("resp_len", resp_len, e.len);
            check("start_seen", m_start_or, e.start_oh);
            check("tready_beats", m_beats, e.beats);
            check("err_writes", m_errw, e.errw);
            check("timeout_pulses", m_tos, e.tos);
            if (e.runc >= 0) check("run_cycles", m_runc, e.runc);
          end
          m_beats = 0; m_errw = 0; m_tos = 0; m_runc = 0; m_start_or = '0;
        end
      end
    end
  end

  // Behavioural handler: consume its packet, optionally emit spurious done, then finish.
  initial begin : handler
    int slot, got, stalls, g;
    cmd_tready = '0;
    done       = '0;
    packet_len = '0;
    forever begin
      @(negedge clk);
      if (hnd_en && start != '0) begin
        slot = 0;
        for (int i = 3; i >= 0; i--) if (start[i]) slot = i;
        got = 0; stalls = 0; g = 0;
        while (got < hnd_bytes && start != '0 && g < 50) begin
          @(posedge clk); #1;
          g++;
          cmd_tready = '0;
          if (stalls < 2 && $urandom_range(0, 3) == 0) stalls++;
          else cmd_tready[slot] = 1'b1;
          @(negedge clk);
          if (dap_in_tvalid && dap_in_tready) got++;
        end
        @(posedge clk); #1;
        cmd_tready = '0;
        if (hnd_spur) begin
          done = 4'hF & ~(4'b0001 << slot);
          @(posedge clk); #1;
          done = '0;
        end
        if (hnd_mode == 2) begin
          g = 0;
          while (run_cyc < 15 && g < 40) begin
            @(posedge clk); #1;
            g++;
          end
        end
        if (hnd_mode != 1) begin
          done[slot] = 1'b1;
          packet_len = hnd_plen;
          @(posedge clk); #1;
          done       = '0;
          packet_len = 10'($urandom);
        end
        g = 0;
        while (start != '0 && g < 100) begin
          @(negedge clk);
          g++;
        end
      end
    end
  end

  // Issue one command: queue the model's prediction, stream bytes, complete the response.
  task automatic do_cmd(input logic [7:0] id, input int nbytes, input logic [9:0] plen,
                        input int mode, input bit spur);
    exp_t       e;
    int         slot, n, k, cyc, d;
    bit         acc;
    logic [7:0] bytes [8];
    slot = ref_slot(id);
    n    = (slot < 0) ? 1 : nbytes;
    if (slot < 0) begin
      e.len = 10'd1; e.start_oh = '0; e.beats = 1; e.errw = 1; e.tos = 0; e.runc = 0;
    end else if (mode == 1) begin
      e.len = 10'd1; e.start_oh = 4'(1 << slot); e.beats = n; e.errw = 1; e.tos = 1;
      e.runc = int'(TMO);
    end else begin
      e.len = plen; e.start_oh = 4'(1 << slot); e.beats = n; e.errw = 0; e.tos = 0;
      e.runc = (mode == 2) ? int'(TMO) : -1;
    end
    sb_q.push_back(e);
    hnd_bytes = n; hnd_plen = plen; hnd_mode = mode; hnd_spur = spur;
    bytes[0] = id;
    for (int i = 1; i < 8; i++) bytes[i] = 8'($urandom);

    dap_in_tvalid = 1'b1;
    dap_in_tdata  = bytes[0];
    k = 0; cyc = 0;
    while (k < n && cyc < 200) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("peek_idle_busy", busy, 1'b0);
        check("peek_idle_tready", dap_in_tready, 1'b0);
      end
      if (cyc == 1) begin
        check("decode_busy", busy, 1'b1);
        check("decode_start", start, 4'b0000);
        check("decode_tready", dap_in_tready, 1'b0);
      end
      if (cyc == 2) check("start_latency", start, e.start_oh);
      acc = dap_in_tready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k++;
        if (k < n) dap_in_tdata = bytes[k];
        else dap_in_tvalid = 1'b0;
      end
    end
    check("stream_consumed", k, n);
    dap_in_tvalid = 1'b0;

    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 100);
    check("resp_valid_seen", resp_valid, 1'b1);
    d = $urandom_range(0, 3);
    repeat (d) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("resp_valid_hold", resp_valid, 1'b1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] id;
    int         mode;
    reset = 1'b1; dap_in_tvalid = 1'b0; dap_in_tdata = '0; resp_ready = 1'b0;
    #3;
    check("rst_start", start, 4'b0000);
    check("rst_tready", dap_in_tready, 1'b0);
    check("rst_err_en", err_ram_write_en, 1'b0);
    check("rst_err_addr", err_ram_write_addr, 10'd0);
    check("rst_err_data", err_ram_write_data, 8'h00);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_len", resp_len, 10'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_cmd(8'h12, 3, 10'd2, 0, 1'b0);       // SWJ_Sequence, 3-byte packet
    do_cmd(8'h7E, 1, 10'd0, 0, 1'b0);       // unmapped ID
    do_cmd(8'h05, 2, 10'd0, 1, 1'b0);       // hung handler -> timeout
    do_cmd(8'h06, 4, 10'h3FF, 0, 1'b1);     // spurious done elsewhere; duplicate ID -> slot 1
    do_cmd(8'h05, 3, 10'd7, 2, 1'b0);       // done coincides with timeout
    do_cmd(8'h12, 5, 10'd0, 2, 1'b1);

    // Reset in the middle of RUN.
    hnd_en = 1'b0; mon_en = 1'b0;
    dap_in_tvalid = 1'b1; dap_in_tdata = 8'h12;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_run_start", start, 4'b0100);
    #2 reset = 1'b1;
    #1;
    check("mid_run_rst_start", start, 4'b0000);
    check("mid_run_rst_busy", busy, 1'b0);
    check("mid_run_rst_tready", dap_in_tready, 1'b0);
    @(posedge clk); #1;
    dap_in_tvalid = 1'b0;
    reset = 1'b0;

    // Reset in the middle of RESP.
    dap_in_tvalid = 1'b1; dap_in_tdata = 8'h7E;
    repeat (3) @(posedge clk);
    #1;
    dap_in_tvalid = 1'b0;
    @(negedge clk);
    check("mid_resp_valid", resp_valid, 1'b1);
    check("mid_resp_len", resp_len, 10'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_resp_rst_valid", resp_valid, 1'b0);
    check("mid_resp_rst_len", resp_len, 10'd0);
    check("mid_resp_rst_busy", busy, 1'b0);
    check("mid_resp_rst_err_en", err_ram_write_en, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    hnd_en = 1'b1; mon_en = 1'b1;

    do_cmd(8'h12, 3, 10'd2, 0, 1'b0);       // dispatches normally after reset

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 4) id = 8'($urandom);
      else id = ref_ids[$urandom_range(0, 3)];
      case ($urandom_range(0, 7))
        0:       mode = 1;
        1:       mode = 2;
        default: mode = 0;
      endcase
      do_cmd(id, $urandom_range(1, 6), 10'($urandom), mode, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("final_idle", busy, 1'b0);
    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
